// File: rtl/ysyx_25030081_ifu_pkg.sv
// Shared IFU types and constants: reset PC, FSM state encoding, RV32 field slices.
package ysyx_25030081_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ILEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25030081_ifu_if.sv
// Instruction-memory request/response channel between the IFU (master) and imem (slave).
interface ysyx_25030081_ifu_if
  import ysyx_25030081_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/ysyx_25030081_ifu_pc.sv
// Program counter: redirect beats sequential advance, otherwise hold.
module ysyx_25030081_ifu_pc
  import ysyx_25030081_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_c
);

  always_comb begin
    pc_next_c = pc;
    if (redirect)     pc_next_c = target;
    else if (advance) pc_next_c = pc + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next_c;
  end

endmodule

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: one outstanding imem read, registered instruction buffer, redirects.
// Optional YSYX_25030081_IFU_MISALIGN_EN reports misaligned redirect targets instead of fetching.
module ysyx_25030081_ifu
  import ysyx_25030081_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_25030081_ifu_if.master imem,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [ILEN-1:0]     inst,
  output logic [XLEN-1:0]     inst_pc,
`ifdef YSYX_25030081_IFU_MISALIGN_EN
  output logic                inst_misalign,
`endif
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT3_W-1:0] funct3,
  output logic [FUNCT7_W-1:0] funct7
);

  ifu_state_e      state, state_next;
  logic            kill, kill_next;
  logic            inst_load, advance, bad_redir;
  logic            misalign_q, parked;
  logic [XLEN-1:0] pc, pc_next, redir_target, req_addr;

`ifdef YSYX_25030081_IFU_MISALIGN_EN
  assign bad_redir     = redirect_valid && is_misaligned(redirect_pc[1:0]);
  assign redir_target  = redirect_pc;
  assign inst_misalign = misalign_q;

  // Misaligned entry lives in HOLD; once consumed the FSM parks in IDLE until a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      parked     <= 1'b0;
    end else begin
      misalign_q <= bad_redir | (misalign_q & (state_next == HOLD));
      parked     <= (state_next == IDLE);
    end
  end
`else
  assign bad_redir    = 1'b0;
  assign redir_target = redirect_pc & ~XLEN'(3);
  assign misalign_q   = 1'b0;
  assign parked       = 1'b0;
`endif

  ysyx_25030081_ifu_pc #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .redirect  (redirect_valid),
    .target    (redir_target),
    .advance   (advance),
    .pc        (pc),
    .pc_next_c (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // kill marks the single outstanding response as stale once the PC has been redirected.
  always_comb begin
    state_next = state;
    kill_next  = kill;
    inst_load  = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: if (!parked || redirect_valid) state_next = REQ;
      REQ: begin
        if (imem.imem_req_ready) state_next = WAIT;
        if (redirect_valid)      kill_next  = 1'b1;
      end
      WAIT: begin
        if (imem.imem_resp_valid) begin
          kill_next = 1'b0;
          if (kill || redirect_valid) begin
            state_next = REQ;
          end else begin
            inst_load  = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect_valid) begin
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_next = REQ;
        end else if (inst_ready) begin
          state_next = misalign_q ? IDLE : REQ;
          advance    = !misalign_q;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bad_redir) begin
      state_next = HOLD;
      inst_load  = 1'b0;
      kill_next  = (state == REQ  &&  imem.imem_req_ready) ||
                   (state == WAIT && !imem.imem_resp_valid) ||
                   (kill && state != REQ);
    end
  end

  always_comb begin
    imem.imem_req_valid = 1'b0;
    inst_valid          = 1'b0;
    unique case (state)
      REQ:     imem.imem_req_valid = 1'b1;
      HOLD:    inst_valid          = 1'b1;
      default: ;
    endcase
  end

  // Request address is captured on entry to REQ so a later redirect cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill     <= 1'b0;
      req_addr <= '0;
      inst     <= '0;
      inst_pc  <= '0;
    end else begin
      kill <= kill_next;
      if (state_next == REQ && state != REQ) req_addr <= pc_next;
      if (bad_redir) begin
        inst    <= '0;
        inst_pc <= redirect_pc;
      end else if (inst_load) begin
        inst    <= imem.imem_resp_data;
        inst_pc <= pc;
      end
    end
  end

  assign imem.imem_req_addr = req_addr;
  assign opcode = inst[OPCODE_LSB +: OPCODE_W];
  assign funct3 = inst[FUNCT3_LSB +: FUNCT3_W];
  assign funct7 = inst[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Directed bench for ysyx_25030081_ifu with an imem model and request/instruction scoreboards.
module tb_ysyx_25030081_ifu;
  import ysyx_25030081_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_inst_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
`ifdef YSYX_25030081_IFU_MISALIGN_EN
  logic        inst_misalign;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cnt = 0;
  int hs_base;
  int n;

  logic [31:0] exp_addr_q[$];
  exp_inst_t   exp_inst_q[$];
  int          consume_cyc_q[$];
  exp_inst_t   mon_e;

  int          mem_lat   = 0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;

  ysyx_25030081_ifu_if imem_bus ();

  assign imem_bus.imem_req_ready = mem_ready;

  ysyx_25030081_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem_bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef YSYX_25030081_IFU_MISALIGN_EN
    .inst_misalign  (inst_misalign),
`endif
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[19:0], 12'h000} ^ 32'h0000_0093;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst_valid(input int max, input string tag);
    int k = 0;
    while (!inst_valid && k < max) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(inst_valid), 32'(1));
  endtask

  // Request and consume monitors; they see pre-edge values at the rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
      hs_cnt++;
      pend      = 1'b1;
      pend_addr = imem_bus.imem_req_addr;
      pend_wait = mem_lat;
      check("req_expected", 32'(exp_addr_q.size() != 0), 32'(1));
      if (exp_addr_q.size() != 0) check("req_addr", imem_bus.imem_req_addr, exp_addr_q.pop_front());
    end
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      consume_cyc_q.push_back(cyc);
      check("consume_expected", 32'(exp_inst_q.size() != 0), 32'(1));
      if (exp_inst_q.size() != 0) begin
        mon_e = exp_inst_q.pop_front();
        check("inst", inst, mon_e.inst);
        check("inst_pc", inst_pc, mon_e.pc);
        check("opcode", 32'(opcode), 32'(mon_e.inst[6:0]));
        check("funct3", 32'(funct3), 32'(mon_e.inst[14:12]));
        check("funct7", 32'(funct7), 32'(mon_e.inst[31:25]));
      end
    end
  end

  // Memory response: mem_lat extra cycles after the accepting edge.
  always @(negedge clk) begin
    if (pend && pend_wait == 0) begin
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = memfn(pend_addr);
      pend = 1'b0;
    end else begin
      imem_bus.imem_resp_valid = 1'b0;
      imem_bus.imem_resp_data  = '0;
      if (pend) pend_wait--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'(0));
    check("rst_req_addr", imem_bus.imem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'(0));
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
`ifdef YSYX_25030081_IFU_MISALIGN_EN
    check("rst_misalign", 32'(inst_misalign), 32'(0));
`endif

    // 1: first fetch after reset
    exp_addr_q.push_back(32'h8000_0000);
    exp_inst_q.push_back('{inst: memfn(32'h8000_0000), pc: 32'h8000_0000});
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_req_valid", 32'(imem_bus.imem_req_valid), 32'(1));
    check("t1_req_addr", imem_bus.imem_req_addr, 32'h8000_0000);
    wait_inst_valid(10, "t1_inst_valid");
    check("t1_inst", inst, 32'h0000_0093);
    check("t1_opcode", 32'(opcode), 32'h13);
    check("t1_funct3", 32'(funct3), 32'h0);
    exp_addr_q.push_back(32'h8000_0004);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0; mem_ready = 1'b0; hs_base = hs_cnt;

    // 2: request held stable under memory backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_req_valid", 32'(imem_bus.imem_req_valid), 32'(1));
      check("t2_req_addr", imem_bus.imem_req_addr, 32'h8000_0004);
    end
    exp_inst_q.push_back('{inst: memfn(32'h8000_0004), pc: 32'h8000_0004});
    mem_ready = 1'b1;
    wait_inst_valid(10, "t2_inst_valid");
    check("t2_one_req", 32'(hs_cnt - hs_base), 32'(1));

    // 3: decode backpressure in HOLD
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_inst_valid", 32'(inst_valid), 32'(1));
      check("t3_inst", inst, memfn(32'h8000_0004));
      check("t3_inst_pc", inst_pc, 32'h8000_0004);
      check("t3_no_req", 32'(imem_bus.imem_req_valid), 32'(0));
    end
    exp_addr_q.push_back(32'h8000_0008);
    inst_ready = 1'b1; mem_lat = 2; hs_base = hs_cnt;
    @(negedge clk);
    inst_ready = 1'b0;

    // 4: redirect while waiting on a slow response
    n = 0;
    while (hs_cnt == hs_base && n < 10) begin @(negedge clk); n++; end
    check("t4_hs", 32'(hs_cnt - hs_base), 32'(1));
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; mem_lat = 0;
    exp_addr_q.push_back(32'h8000_0100);
    exp_inst_q.push_back('{inst: memfn(32'h8000_0100), pc: 32'h8000_0100});
    @(negedge clk);
    redirect_valid = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    check("t4_inst_valid", 32'(inst_valid), 32'(1));
    check("t4_inst_pc", inst_pc, 32'h8000_0100);
    check("t4_inst", inst, memfn(32'h8000_0100));
    check("t4_req_count", 32'(hs_cnt - hs_base), 32'(2));

    // 5: redirect and consume in the same HOLD cycle
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    void'(exp_inst_q.pop_front());
    exp_addr_q.push_back(32'h8000_0200);
    exp_inst_q.push_back('{inst: memfn(32'h8000_0200), pc: 32'h8000_0200});
    @(negedge clk);
    redirect_valid = 1'b0; inst_ready = 1'b0;
    check("t5_discard", 32'(inst_valid), 32'(0));
    check("t5_req_valid", 32'(imem_bus.imem_req_valid), 32'(1));
    check("t5_req_addr", imem_bus.imem_req_addr, 32'h8000_0200);
    wait_inst_valid(10, "t5_inst_valid");
    check("t5_inst_pc", inst_pc, 32'h8000_0200);

    // PC wrap and back-to-back throughput
    redirect_valid = 1'b1;
`ifdef YSYX_25030081_IFU_MISALIGN_EN
    redirect_pc = 32'hFFFF_FFF8;
`else
    redirect_pc = 32'hFFFF_FFFA;
`endif
    void'(exp_inst_q.pop_front());
    exp_addr_q.push_back(32'hFFFF_FFF8);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_inst_q.push_back('{inst: memfn(32'hFFFF_FFF8), pc: 32'hFFFF_FFF8});
    exp_inst_q.push_back('{inst: memfn(32'hFFFF_FFFC), pc: 32'hFFFF_FFFC});
    exp_inst_q.push_back('{inst: memfn(32'h0000_0000), pc: 32'h0000_0000});
    @(negedge clk);
    redirect_valid = 1'b0; inst_ready = 1'b1;
    consume_cyc_q.delete();
    n = 0;
    while (exp_inst_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    inst_ready = 1'b0;
    check("wrap_drained", 32'(exp_inst_q.size()), 32'(0));
    check("tput_count", 32'(consume_cyc_q.size()), 32'(3));
    if (consume_cyc_q.size() >= 3) begin
      check("tput_gap0", 32'(consume_cyc_q[1] - consume_cyc_q[0]), 32'(3));
      check("tput_gap1", 32'(consume_cyc_q[2] - consume_cyc_q[1]), 32'(3));
    end
    wait_inst_valid(10, "wrap_inst_valid");
    check("wrap_inst_pc", inst_pc, 32'h0000_0004);

`ifdef YSYX_25030081_IFU_MISALIGN_EN
    // 6: misaligned redirect becomes a flagged entry, then the IFU parks
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t6_no_req", 32'(imem_bus.imem_req_valid), 32'(0));
    check("t6_inst_valid", 32'(inst_valid), 32'(1));
    check("t6_misalign", 32'(inst_misalign), 32'(1));
    check("t6_inst", inst, 32'h0);
    check("t6_inst_pc", inst_pc, 32'h8000_0102);
    exp_inst_q.push_back('{inst: 32'h0, pc: 32'h8000_0102});
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_parked_req", 32'(imem_bus.imem_req_valid), 32'(0));
      check("t6_parked_valid", 32'(inst_valid), 32'(0));
    end
    exp_addr_q.push_back(32'h8000_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t6_resume_req", 32'(imem_bus.imem_req_valid), 32'(1));
    check("t6_resume_addr", imem_bus.imem_req_addr, 32'h8000_0000);
    check("t6_misalign_clr", 32'(inst_misalign), 32'(0));
`endif

    repeat (4) @(negedge clk);
    check("end_addr_q", 32'(exp_addr_q.size()), 32'(0));
    check("end_inst_q", 32'(exp_inst_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
